// File: rtl/uc_pkg.sv
// Shared encodings for the multicycle RV64 control unit: states, opcodes, funct3 codes,
// ALU commands and alu_flags bit positions.
package uc_pkg;

  typedef enum logic [3:0] {
    ST_FETCH   = 4'd0,
    ST_DECODE  = 4'd1,
    ST_EXEC_R  = 4'd2,
    ST_EXEC_I  = 4'd3,
    ST_ADDR    = 4'd4,
    ST_MEM_RD  = 4'd5,
    ST_MEM_WR  = 4'd6,
    ST_WB_ALU  = 4'd7,
    ST_WB_MEM  = 4'd8,
    ST_BRANCH  = 4'd9,
    ST_ILLEGAL = 4'd10,
    ST_HALT    = 4'd11
  } uc_state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADDI = 3'b000;
  localparam logic [2:0] F3_DW   = 3'b011;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 2;

  function automatic logic is_branch_f3(input logic [2:0] f3);
    return (f3 == F3_BEQ) || (f3 == F3_BNE) || (f3 == F3_BLT) || (f3 == F3_BGE);
  endfunction

endpackage

// File: rtl/uc_multicycle_if.sv
// Control-unit <-> datapath bundle: IR fields, flags, memory readies in; strobes, selects, debug out.
interface uc_multicycle_if #(parameter int CNT_W = 32);

  logic [6:0]       opcode;
  logic [2:0]       funct3;
  logic             funct7_b30;
  logic [3:0]       alu_flags;
  logic             i_mem_ready;
  logic             d_mem_ready;
  logic             ir_we;
  logic             pc_we;
  logic             pc_src;
  logic             rf_we;
  logic             rf_src;
  logic             alu_src;
  logic [3:0]       alu_cmd;
  logic             d_mem_we;
  logic             halt;
  logic [3:0]       state_o;
  logic [CNT_W-1:0] instret;

  modport master (
    input  opcode, funct3, funct7_b30, alu_flags, i_mem_ready, d_mem_ready,
    output ir_we, pc_we, pc_src, rf_we, rf_src, alu_src, alu_cmd, d_mem_we, halt, state_o, instret
  );

  modport slave (
    output opcode, funct3, funct7_b30, alu_flags, i_mem_ready, d_mem_ready,
    input  ir_we, pc_we, pc_src, rf_we, rf_src, alu_src, alu_cmd, d_mem_we, halt, state_o, instret
  );

endinterface

// File: rtl/uc_branch_eval.sv
// Branch condition evaluation from funct3 and the ALU flags of rs1-rs2.
module uc_branch_eval
  import uc_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic [3:0] alu_flags,
  output logic       taken
);

  logic lt_s;
  logic flag_unused_s;

  assign lt_s          = alu_flags[FLAG_N] ^ alu_flags[FLAG_V];
  assign flag_unused_s = alu_flags[3];

  // taken decode per branch kind
  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3_BEQ:  taken = alu_flags[FLAG_Z];
      F3_BNE:  taken = ~alu_flags[FLAG_Z];
      F3_BLT:  taken = lt_s;
      F3_BGE:  taken = ~lt_s;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/uc_multicycle.sv
// Multicycle control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with instret counter.
// UC_ILLEGAL_TRAP_EN: illegal instructions halt the unit instead of retiring as NOP.
module uc_multicycle
  import uc_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input logic           clk,
  input logic           rst_n,
  uc_multicycle_if.master bus
);

  uc_state_e        state_r;
  uc_state_e        next_s;
  logic [CNT_W-1:0] instret_r;
  logic             taken_s;
  logic             ir_we_s, pc_we_s, pc_src_s, rf_we_s, rf_src_s, alu_src_s, d_mem_we_s;
  logic [3:0]       alu_cmd_s;

  uc_branch_eval u_branch_eval (
    .funct3    (bus.funct3),
    .alu_flags (bus.alu_flags),
    .taken     (taken_s)
  );

  // state register and retire counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= ST_FETCH;
      instret_r <= '0;
    end else begin
      state_r <= next_s;
      if (pc_we_s) begin
        instret_r <= instret_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // next-state and strobe decode
  always_comb begin
    next_s     = state_r;
    ir_we_s    = 1'b0;
    pc_we_s    = 1'b0;
    pc_src_s   = 1'b0;
    rf_we_s    = 1'b0;
    rf_src_s   = 1'b0;
    alu_src_s  = 1'b0;
    alu_cmd_s  = 4'b0000;
    d_mem_we_s = 1'b0;
    case (state_r)
      ST_FETCH: begin
        ir_we_s = bus.i_mem_ready;
        if (bus.i_mem_ready) next_s = ST_DECODE;
        else                 next_s = ST_FETCH;
      end
      ST_DECODE: begin
        case (bus.opcode)
          OP_R:      next_s = ST_EXEC_R;
          OP_IMM:    next_s = (bus.funct3 == F3_ADDI) ? ST_EXEC_I : ST_ILLEGAL;
          OP_LOAD:   next_s = (bus.funct3 == F3_DW) ? ST_ADDR : ST_ILLEGAL;
          OP_STORE:  next_s = (bus.funct3 == F3_DW) ? ST_ADDR : ST_ILLEGAL;
          OP_BRANCH: next_s = is_branch_f3(bus.funct3) ? ST_BRANCH : ST_ILLEGAL;
          default:   next_s = ST_ILLEGAL;
        endcase
      end
      ST_EXEC_R: begin
        alu_cmd_s = bus.funct7_b30 ? ALU_SUB : ALU_ADD;
        next_s    = ST_WB_ALU;
      end
      ST_EXEC_I: begin
        alu_src_s = 1'b1;
        alu_cmd_s = ALU_ADD;
        next_s    = ST_WB_ALU;
      end
      ST_ADDR: begin
        alu_src_s = 1'b1;
        alu_cmd_s = ALU_ADD;
        next_s    = (bus.opcode == OP_STORE) ? ST_MEM_WR : ST_MEM_RD;
      end
      ST_MEM_RD: begin
        alu_src_s = 1'b1;
        alu_cmd_s = ALU_ADD;
        if (bus.d_mem_ready) next_s = ST_WB_MEM;
        else                 next_s = ST_MEM_RD;
      end
      ST_MEM_WR: begin
        alu_src_s  = 1'b1;
        alu_cmd_s  = ALU_ADD;
        d_mem_we_s = 1'b1;
        if (bus.d_mem_ready) begin
          pc_we_s = 1'b1;
          next_s  = ST_FETCH;
        end else begin
          next_s  = ST_MEM_WR;
        end
      end
      ST_WB_ALU: begin
        // IR is still stable, so EXEC's ALU controls are re-derived rather than stored
        rf_we_s   = 1'b1;
        alu_src_s = (bus.opcode == OP_IMM);
        alu_cmd_s = ((bus.opcode == OP_R) && bus.funct7_b30) ? ALU_SUB : ALU_ADD;
        pc_we_s   = 1'b1;
        next_s    = ST_FETCH;
      end
      ST_WB_MEM: begin
        rf_we_s  = 1'b1;
        rf_src_s = 1'b1;
        pc_we_s  = 1'b1;
        next_s   = ST_FETCH;
      end
      ST_BRANCH: begin
        alu_cmd_s = ALU_SUB;
        pc_we_s   = 1'b1;
        pc_src_s  = taken_s;
        next_s    = ST_FETCH;
      end
`ifdef UC_ILLEGAL_TRAP_EN
      ST_ILLEGAL: next_s = ST_HALT;
      ST_HALT:    next_s = ST_HALT;
`else
      ST_ILLEGAL: begin
        pc_we_s = 1'b1;
        next_s  = ST_FETCH;
      end
      ST_HALT:    next_s = ST_FETCH;
`endif
      default:    next_s = ST_FETCH;
    endcase
  end

`ifdef UC_ILLEGAL_TRAP_EN
  logic halt_r;

  // sticky halt flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      halt_r <= 1'b0;
    end else if (next_s == ST_HALT) begin
      halt_r <= 1'b1;
    end
  end

  assign bus.halt = halt_r;
`else
  assign bus.halt = 1'b0;
`endif

  // reset forces every strobe and select low in the same cycle
  assign bus.ir_we    = rst_n & ir_we_s;
  assign bus.pc_we    = rst_n & pc_we_s;
  assign bus.pc_src   = rst_n & pc_src_s;
  assign bus.rf_we    = rst_n & rf_we_s;
  assign bus.rf_src   = rst_n & rf_src_s;
  assign bus.alu_src  = rst_n & alu_src_s;
  assign bus.alu_cmd  = alu_cmd_s & {4{rst_n}};
  assign bus.d_mem_we = rst_n & d_mem_we_s;
  assign bus.state_o  = state_r;
  assign bus.instret  = instret_r;

endmodule

// File: tb/tb_uc_multicycle.sv
// Scoreboard bench for uc_multicycle: driver pushes expected retire records, monitor checks them.
module tb_uc_multicycle;
  import uc_pkg::*;

  typedef struct {
    string      name;
    int         lat;
    logic [3:0] st;
    logic       pc_src;
    logic       rf_we;
    logic       rf_src;
    logic [3:0] alu_cmd;
    logic       alu_src;
    int         dwe;
    int         rfwe;
    logic [31:0] inst;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_instret = 32'd0;
  exp_t        sb_q[$];
  exp_t        m_e;
  int          m_cyc = 0;
  int          m_dwe = 0;
  int          m_rfwe = 0;

  always #5 clk = ~clk;

  uc_multicycle_if #(.CNT_W(32)) bus ();

  uc_multicycle #(.CNT_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic exp_t mk(input string nm, input int lat, input logic [3:0] st,
                              input logic pcs, input logic rfw, input logic rfs,
                              input logic [3:0] cmd, input logic asrc, input int dwe, input int rfwe);
    exp_t e;
    e.name = nm; e.lat = lat; e.st = st; e.pc_src = pcs; e.rf_we = rfw; e.rf_src = rfs;
    e.alu_cmd = cmd; e.alu_src = asrc; e.dwe = dwe; e.rfwe = rfwe; e.inst = 32'd0;
    return e;
  endfunction

  function automatic logic [31:0] strobes();
    return 32'({bus.ir_we, bus.pc_we, bus.rf_we, bus.d_mem_we, bus.pc_src,
                bus.rf_src, bus.alu_src, bus.alu_cmd});
  endfunction

  // monitor: every retire (pc_we) pops one record and compares the whole instruction
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_cyc = 0; m_dwe = 0; m_rfwe = 0;
      end else begin
        m_cyc++;
        if (bus.d_mem_we) m_dwe++;
        if (bus.rf_we) m_rfwe++;
        if (bus.pc_we) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_retire", 32'd1, 32'd0);
          end else begin
            m_e = sb_q.pop_front();
            chk({m_e.name, "_lat"},     32'(m_cyc),       32'(m_e.lat));
            chk({m_e.name, "_state"},   32'(bus.state_o), 32'(m_e.st));
            chk({m_e.name, "_pc_src"},  32'(bus.pc_src),  32'(m_e.pc_src));
            chk({m_e.name, "_rf_we"},   32'(bus.rf_we),   32'(m_e.rf_we));
            chk({m_e.name, "_rf_src"},  32'(bus.rf_src),  32'(m_e.rf_src));
            chk({m_e.name, "_alu_cmd"}, 32'(bus.alu_cmd), 32'(m_e.alu_cmd));
            chk({m_e.name, "_alu_src"}, 32'(bus.alu_src), 32'(m_e.alu_src));
            chk({m_e.name, "_dwe_cyc"}, 32'(m_dwe),       32'(m_e.dwe));
            chk({m_e.name, "_rfwe_cyc"},32'(m_rfwe),      32'(m_e.rfwe));
            chk({m_e.name, "_instret"}, bus.instret,      m_e.inst);
          end
          m_cyc = 0; m_dwe = 0; m_rfwe = 0;
        end
      end
    end
  end

  // driver: called at posedge+1 with the DUT in FETCH; returns at posedge+1 after retire
  task automatic run(input logic [31:0] ir, input logic [3:0] flags, input int iw, input int dw,
                     input exp_t e);
    int  icnt = 0;
    int  dcnt = 0;
    bit  done = 1'b0;
    e.inst = exp_instret;
    sb_q.push_back(e);
    exp_instret = exp_instret + 32'd1;
    bus.opcode     = ir[6:0];
    bus.funct3     = ir[14:12];
    bus.funct7_b30 = ir[30];
    bus.alu_flags  = flags;
    for (int c = 0; c < 60 && !done; c++) begin
      if (bus.state_o == ST_FETCH && icnt < iw) begin
        bus.i_mem_ready = 1'b0; icnt++;
      end else begin
        bus.i_mem_ready = 1'b1;
      end
      if ((bus.state_o == ST_MEM_RD || bus.state_o == ST_MEM_WR) && dcnt < dw) begin
        bus.d_mem_ready = 1'b0; dcnt++;
      end else begin
        bus.d_mem_ready = 1'b1;
      end
      @(negedge clk);
      if (bus.pc_we) done = 1'b1;
      @(posedge clk); #1;
    end
    if (!done) chk({e.name, "_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    bus.opcode = 7'd0; bus.funct3 = 3'd0; bus.funct7_b30 = 1'b0; bus.alu_flags = 4'd0;
    bus.i_mem_ready = 1'b1; bus.d_mem_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_strobes", strobes(), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("rst_state", 32'(bus.state_o), 32'(ST_FETCH));
    chk("rst_instret", bus.instret, 32'd0);
    chk("rst_halt", 32'(bus.halt), 32'd0);

    run(32'h002081B3, 4'b0000, 0, 0, mk("add",    4, ST_WB_ALU, 1'b0, 1'b1, 1'b0, ALU_ADD, 1'b0, 0, 1));
    run(32'h402081B3, 4'b0000, 0, 0, mk("sub",    4, ST_WB_ALU, 1'b0, 1'b1, 1'b0, ALU_SUB, 1'b0, 0, 1));
    run(32'h00508093, 4'b0000, 0, 0, mk("addi",   4, ST_WB_ALU, 1'b0, 1'b1, 1'b0, ALU_ADD, 1'b1, 0, 1));
    run(32'h002081B3, 4'b0000, 2, 0, mk("add_iw", 6, ST_WB_ALU, 1'b0, 1'b1, 1'b0, ALU_ADD, 1'b0, 0, 1));
    run(32'h00003483, 4'b0000, 0, 3, mk("ld",     8, ST_WB_MEM, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b0, 0, 1));
    run(32'h00A03423, 4'b0000, 0, 2, mk("sd",     6, ST_MEM_WR, 1'b0, 1'b0, 1'b0, ALU_ADD, 1'b1, 3, 0));
    run(32'h00000463, 4'b0001, 0, 0, mk("beq_z1", 3, ST_BRANCH, 1'b1, 1'b0, 1'b0, ALU_SUB, 1'b0, 0, 0));
    run(32'h00000463, 4'b0000, 0, 0, mk("beq_z0", 3, ST_BRANCH, 1'b0, 1'b0, 1'b0, ALU_SUB, 1'b0, 0, 0));
    run(32'h00001463, 4'b0001, 0, 0, mk("bne_z1", 3, ST_BRANCH, 1'b0, 1'b0, 1'b0, ALU_SUB, 1'b0, 0, 0));
    run(32'h00004463, 4'b0010, 0, 0, mk("blt_n1", 3, ST_BRANCH, 1'b1, 1'b0, 1'b0, ALU_SUB, 1'b0, 0, 0));
    run(32'h00004463, 4'b0110, 0, 0, mk("blt_nv", 3, ST_BRANCH, 1'b0, 1'b0, 1'b0, ALU_SUB, 1'b0, 0, 0));
    run(32'h00005463, 4'b0110, 0, 0, mk("bge_nv", 3, ST_BRANCH, 1'b1, 1'b0, 1'b0, ALU_SUB, 1'b0, 0, 0));
    run(32'h00005463, 4'b0010, 0, 0, mk("bge_n1", 3, ST_BRANCH, 1'b0, 1'b0, 1'b0, ALU_SUB, 1'b0, 0, 0));
    chk("instret_total", bus.instret, exp_instret);

    // reset in the middle of a stalled store
    bus.opcode = 7'b0100011; bus.funct3 = 3'b011; bus.funct7_b30 = 1'b0;
    bus.i_mem_ready = 1'b1; bus.d_mem_ready = 1'b0;
    for (int c = 0; c < 20 && bus.state_o != ST_MEM_WR; c++) begin
      @(posedge clk); #1;
    end
    chk("midrst_reach_memwr", 32'(bus.state_o), 32'(ST_MEM_WR));
    @(negedge clk);
    chk("midrst_dwe_before", 32'(bus.d_mem_we), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("midrst_strobes", strobes(), 32'd0);
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    bus.d_mem_ready = 1'b1;
    exp_instret = 32'd0;
    #1;
    chk("midrst_state", 32'(bus.state_o), 32'(ST_FETCH));
    chk("midrst_instret", bus.instret, 32'd0);
    run(32'h002081B3, 4'b0000, 0, 0, mk("add_post", 4, ST_WB_ALU, 1'b0, 1'b1, 1'b0, ALU_ADD, 1'b0, 0, 1));

`ifdef UC_ILLEGAL_TRAP_EN
    bus.opcode = 7'h7F; bus.funct3 = 3'b000; bus.funct7_b30 = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("halt_state", 32'(bus.state_o), 32'(ST_HALT));
      chk("halt_flag", 32'(bus.halt), 32'd1);
      chk("halt_strobes", strobes(), 32'd0);
      chk("halt_instret", bus.instret, exp_instret);
    end
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_instret = 32'd0;
    #1;
    chk("halt_cleared", 32'(bus.halt), 32'd0);
    chk("halt_rst_state", 32'(bus.state_o), 32'(ST_FETCH));
`else
    run(32'h0000007F, 4'b0000, 0, 0, mk("illegal", 3, ST_ILLEGAL, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 0, 0));
    chk("illegal_halt", 32'(bus.halt), 32'd0);
    chk("illegal_back_fetch", 32'(bus.state_o), 32'(ST_FETCH));
`endif
    run(32'h402081B3, 4'b0000, 0, 0, mk("sub_end", 4, ST_WB_ALU, 1'b0, 1'b1, 1'b0, ALU_SUB, 1'b0, 0, 1));

    repeat (2) @(posedge clk);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
